// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP48A1 datapath pipeline registers.
package dsp_pkg;
  localparam int          DSP_MAX_DEPTH = 8;
  localparam logic [47:0] DSP_RST_VAL   = '0;

  // Occupancy counter width: clog2(depth+1), never narrower than one bit.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dsp_pipe_reg_if.sv
// Operand/result path bundle for dsp_pipe_reg: control, data in, data out and occupancy.
interface dsp_pipe_reg_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1
);
  import dsp_pkg::*;
  localparam int CNT_W = cnt_w(DEPTH);

  logic             ce;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             empty;

  modport master (output ce, flush, in_valid, in,
                  input  out, out_valid, count, empty);
  modport slave  (input  ce, flush, in_valid, in,
                  output out, out_valid, count, empty);
endinterface

// File: rtl/dsp_pipe_cell.sv
// One pipeline stage: data flop plus valid flop, priority rst > flush > ce > hold.
module dsp_pipe_cell #(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);
  // Flush only kills the valid; data keeps moving with ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else begin
      if (ce) q <= d;
      if (flush)   q_valid <= 1'b0;
      else if (ce) q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/dsp_pipe_reg.sv
// DEPTH-stage pipeline register with valid tracking, flush and occupancy count.
module dsp_pipe_reg
  import dsp_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DSP_RST_VAL),
  localparam int              CNT_W   = cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  dsp_pipe_reg_if.slave  bus
);
  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, bus.ce};

    assign bus.out       = bus.in;
    assign bus.out_valid = bus.in_valid & ~bus.flush;
    assign bus.count     = '0;
    assign bus.empty     = 1'b1;
  end else begin : g_pipe
    // Stage k reads chain[k] and drives chain[k+1]; chain[0] is the input.
    logic [DEPTH:0][WIDTH-1:0] d_chain;
    logic [DEPTH:0]            v_chain;
    logic [CNT_W-1:0]          cnt_q;

    assign d_chain[0] = bus.in;
    assign v_chain[0] = bus.in_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      dsp_pipe_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .ce      (bus.ce),
        .flush   (bus.flush),
        .d       (d_chain[k]),
        .d_valid (v_chain[k]),
        .q       (d_chain[k+1]),
        .q_valid (v_chain[k+1])
      );
    end

    // Tracks population of valid stages; bounded because the valid chain is.
    always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
        cnt_q <= '0;
      end else if (bus.ce) begin
        case ({bus.in_valid, v_chain[DEPTH]})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign bus.out       = d_chain[DEPTH];
    assign bus.out_valid = v_chain[DEPTH];
    assign bus.count     = cnt_q;
    assign bus.empty     = (cnt_q == '0);
  end
endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Drives five dsp_pipe_reg configurations in lockstep and checks them against a stage-array model.
module tb_dsp_pipe_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1, ce = 1'b0, flush = 1'b0, iv = 1'b0;
  logic [47:0] din = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  localparam int NI = 5;
  int          dep   [NI] = '{3, 4, 2, 0, 8};
  logic [47:0] rv    [NI] = '{48'h0, 48'h2A5, 48'h3FFFF, 48'h0, 48'h0};
  logic [47:0] wmask [NI] = '{48'h3FFFF, 48'h3FFFF, 48'h3FFFF, 48'hFFFF_FFFF_FFFF, 48'h3FFFF};

  logic [47:0] o_data [NI];
  logic        o_vld  [NI];
  logic [3:0]  o_cnt  [NI];
  logic        o_empty[NI];

  logic [47:0] m_data [NI][8];
  logic        m_vld  [NI][8];

  dsp_pipe_reg_if #(.WIDTH(18), .DEPTH(3)) b0 ();
  dsp_pipe_reg_if #(.WIDTH(18), .DEPTH(4)) b1 ();
  dsp_pipe_reg_if #(.WIDTH(18), .DEPTH(2)) b2 ();
  dsp_pipe_reg_if #(.WIDTH(48), .DEPTH(0)) b3 ();
  dsp_pipe_reg_if #(.WIDTH(18), .DEPTH(8)) b4 ();

  assign {b0.ce, b0.flush, b0.in_valid, b0.in} = {ce, flush, iv, din[17:0]};
  assign {b1.ce, b1.flush, b1.in_valid, b1.in} = {ce, flush, iv, din[17:0]};
  assign {b2.ce, b2.flush, b2.in_valid, b2.in} = {ce, flush, iv, din[17:0]};
  assign {b3.ce, b3.flush, b3.in_valid, b3.in} = {ce, flush, iv, din};
  assign {b4.ce, b4.flush, b4.in_valid, b4.in} = {ce, flush, iv, din[17:0]};

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(3))                      u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(4), .RST_VAL(18'h2A5))   u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2), .RST_VAL(18'h3FFFF)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  dsp_pipe_reg #(.WIDTH(48), .DEPTH(0))                      u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(8))                      u4 (.clk(clk), .rst(rst), .bus(b4.slave));

  assign o_data[0] = 48'(b0.out); assign o_vld[0] = b0.out_valid; assign o_cnt[0] = 4'(b0.count); assign o_empty[0] = b0.empty;
  assign o_data[1] = 48'(b1.out); assign o_vld[1] = b1.out_valid; assign o_cnt[1] = 4'(b1.count); assign o_empty[1] = b1.empty;
  assign o_data[2] = 48'(b2.out); assign o_vld[2] = b2.out_valid; assign o_cnt[2] = 4'(b2.count); assign o_empty[2] = b2.empty;
  assign o_data[3] = b3.out;      assign o_vld[3] = b3.out_valid; assign o_cnt[3] = 4'(b3.count); assign o_empty[3] = b3.empty;
  assign o_data[4] = 48'(b4.out); assign o_vld[4] = b4.out_valid; assign o_cnt[4] = 4'(b4.count); assign o_empty[4] = b4.empty;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs: last stage of the model, count as the number of valid stages.
  task automatic check_all();
    for (int n = 0; n < NI; n++) begin
      int D = dep[n];
      int pop = 0;
      if (D == 0) begin
        check($sformatf("d0_out"),   o_data[n], din & wmask[n]);
        check($sformatf("d0_vld"),   48'(o_vld[n]), 48'(iv & ~flush));
        check($sformatf("d0_cnt"),   48'(o_cnt[n]), 48'd0);
        check($sformatf("d0_empty"), 48'(o_empty[n]), 48'd1);
      end else begin
        for (int k = 0; k < D; k++) pop += int'(m_vld[n][k]);
        check($sformatf("d%0d_out", D),   o_data[n], m_data[n][D-1]);
        check($sformatf("d%0d_vld", D),   48'(o_vld[n]), 48'(m_vld[n][D-1]));
        check($sformatf("d%0d_cnt", D),   48'(o_cnt[n]), 48'(pop));
        check($sformatf("d%0d_empty", D), 48'(o_empty[n]), 48'(pop == 0));
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit f, input bit v, input logic [47:0] d);
    rst = r; ce = c; flush = f; iv = v; din = d;
    @(posedge clk);
    for (int n = 0; n < NI; n++) begin
      if (dep[n] == 0) continue;
      if (r) begin
        for (int k = 0; k < dep[n]; k++) begin m_data[n][k] = rv[n]; m_vld[n][k] = 1'b0; end
      end else begin
        if (c) begin
          for (int k = dep[n] - 1; k > 0; k--) begin
            m_data[n][k] = m_data[n][k-1];
            m_vld[n][k]  = m_vld[n][k-1];
          end
          m_data[n][0] = d & wmask[n];
          m_vld[n][0]  = v;
        end
        if (f) for (int k = 0; k < dep[n]; k++) m_vld[n][k] = 1'b0;
      end
    end
    #1;
    check_all();
  endtask

  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    step(1, 0, 0, 0, 48'h0);
    step(1, 1, 0, 1, 48'h123);
    check("rst_d2_out",  o_data[2], 48'h3FFFF);
    check("rst_d4_out",  o_data[1], 48'h2A5);
    check("rst_d8_empty", 48'(o_empty[4]), 48'd1);

    // Back-to-back items through DEPTH=3.
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 1, 48'(i));
      check("d3_seq_cnt", 48'(o_cnt[0]), 48'(exp_cnt[i-1]));
      if (i >= 3) begin
        check("d3_seq_out", o_data[0], 48'(i - 2));
        check("d3_seq_vld", 48'(o_vld[0]), 48'd1);
      end
    end

    // Gapped ce: only ce=1 edges advance the item.
    step(0, 1, 1, 0, 48'h0);
    step(0, 1, 0, 1, 48'h155);
    for (int j = 0; j < 4; j++) step(0, bit'(j % 2), 0, bit'(j % 2 == 0), 48'($urandom));
    check("d3_gap_out", o_data[0], 48'h155);
    check("d3_gap_vld", 48'(o_vld[0]), 48'd1);
    step(0, 0, 0, 1, 48'h3);
    check("d3_gap_hold", o_data[0], 48'h155);

    // Fill DEPTH=4, then flush with an incoming valid item.
    step(0, 1, 1, 0, 48'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 48'h10 + 48'(i));
    check("d4_full_cnt", 48'(o_cnt[1]), 48'd4);
    step(0, 1, 1, 1, 48'h99);
    check("d4_flush_vld",   48'(o_vld[1]), 48'd0);
    check("d4_flush_cnt",   48'(o_cnt[1]), 48'd0);
    check("d4_flush_empty", 48'(o_empty[1]), 48'd1);
    check("d4_flush_out",   o_data[1], 48'h11);

    // Reset mid-stream on DEPTH=2.
    step(0, 1, 0, 1, 48'h5);
    step(0, 1, 0, 1, 48'h6);
    step(1, 1, 0, 1, 48'h7);
    check("d2_rst_out", o_data[2], 48'h3FFFF);
    check("d2_rst_vld", 48'(o_vld[2]), 48'd0);
    check("d2_rst_cnt", 48'(o_cnt[2]), 48'd0);
    step(0, 1, 0, 1, 48'hA);
    step(0, 1, 0, 0, 48'h0);
    check("d2_after_rst_out", o_data[2], 48'hA);
    check("d2_after_rst_vld", 48'(o_vld[2]), 48'd1);

    // Bypass.
    step(0, 1, 0, 1, 48'hABCDEF012345);
    check("d0_pass", o_data[3], 48'hABCDEF012345);
    step(0, 0, 1, 1, 48'hABCDEF012345);
    check("d0_flush_vld", 48'(o_vld[3]), 48'd0);

    // Random mix of ce/flush/rst.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 99) == 0), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 1)),
           {16'($urandom), 32'($urandom)});

    // Continuous ce with random valids on DEPTH=8.
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 0, bit'($urandom_range(0, 1)), 48'($urandom));
      check("d8_cnt_le8", 48'(o_cnt[4] <= 4'd8), 48'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
